// File: rtl/llc_evict_buffer.sv
// LLC victim writeback buffer: queues modified victims for memory, drops clean ones,
// answers snoops against buffered lines and sequences flush-until-empty requests.
module llc_evict_buffer #(
  parameter int N_WAY  = 16,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     evict_valid,
  output logic                     evict_ready,
  input  logic [ADDR_W-1:0]        evict_addr,
  input  logic [$clog2(N_WAY)-1:0] evict_way,
  input  logic [1:0]               evict_mesi,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [$clog2(N_WAY)-1:0] wb_way,
  input  logic                     snoop_valid,
  input  logic [ADDR_W-1:0]        snoop_addr,
  output logic                     snoop_hit,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic [15:0]              wb_count,
  output logic [15:0]              drop_count,
  output logic                     dup_err
);

  localparam int WAY_W = $clog2(N_WAY);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [1:0]       MESI_M   = 2'd3;
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [ADDR_W-1:0]  addr_mem_r [DEPTH];
  logic [WAY_W-1:0]   way_mem_r  [DEPTH];
  logic [DEPTH-1:0]   valid_r;
  logic [PTR_W-1:0]   wptr_r;
  logic [PTR_W-1:0]   rptr_r;
  logic [OCC_W-1:0]   occ_r;

  logic accept_s;
  logic push_s;
  logic drop_s;
  logic pop_s;
  logic snoop_match_s;
  logic dup_match_s;

  assign evict_ready = (occ_r != OCC_FULL) && (state_r == IDLE);
  assign wb_valid    = (occ_r != {OCC_W{1'b0}});
  assign wb_addr     = addr_mem_r[rptr_r];
  assign wb_way      = way_mem_r[rptr_r];
  assign accept_s    = evict_valid && evict_ready;
  assign push_s      = accept_s && (evict_mesi == MESI_M);
  assign drop_s      = accept_s && (evict_mesi != MESI_M);
  assign pop_s       = wb_valid && wb_ready;

  // Address match against live entries; the entry popping this cycle is still valid here.
  always_comb begin
    snoop_match_s = 1'b0;
    dup_match_s   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      snoop_match_s = snoop_match_s | (valid_r[i] & (addr_mem_r[i] == snoop_addr));
      dup_match_s   = dup_match_s   | (valid_r[i] & (addr_mem_r[i] == evict_addr));
    end
    snoop_match_s = snoop_match_s | (push_s & (evict_addr == snoop_addr));
  end

  // FIFO storage, per-entry valid bits, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= '0;
        way_mem_r[i]  <= '0;
      end
      valid_r <= '0;
      wptr_r  <= '0;
      rptr_r  <= '0;
      occ_r   <= '0;
    end else begin
      if (pop_s) begin
        valid_r[rptr_r] <= 1'b0;
        rptr_r          <= rptr_r + PTR_W'(1);
      end
      if (push_s) begin
        addr_mem_r[wptr_r] <= evict_addr;
        way_mem_r[wptr_r]  <= evict_way;
        valid_r[wptr_r]    <= 1'b1;
        wptr_r             <= wptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Snoop response, saturating statistics and the sticky duplicate flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snoop_hit  <= 1'b0;
      wb_count   <= 16'd0;
      drop_count <= 16'd0;
      dup_err    <= 1'b0;
    end else begin
      snoop_hit <= snoop_valid && snoop_match_s;
      if (push_s && (wb_count != CNT_MAX)) begin
        wb_count <= wb_count + 16'd1;
      end
      if (drop_s && (drop_count != CNT_MAX)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (push_s && dup_match_s) begin
        dup_err <= 1'b1;
      end
    end
  end

  // Flush sequencer; DRAIN waits for the FIFO to empty, DONE emits the one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      flush_done <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          flush_done <= 1'b0;
          if (flush_req) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (occ_r == {OCC_W{1'b0}}) begin
            state_r    <= DONE;
            flush_done <= 1'b1;
          end else begin
            flush_done <= 1'b0;
          end
        end
        DONE: begin
          state_r    <= IDLE;
          flush_done <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llc_evict_buffer.sv
// Scoreboard bench for llc_evict_buffer: a queue-based reference model predicts every
// edge, a monitor compares DUT outputs at the falling edge and pops expected writebacks.
module tb_llc_evict_buffer;

  localparam int N_WAY  = 16;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int WAY_W  = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WAY_W-1:0]  way;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              evict_valid = 1'b0;
  logic              evict_ready;
  logic [ADDR_W-1:0] evict_addr = '0;
  logic [WAY_W-1:0]  evict_way = '0;
  logic [1:0]        evict_mesi = 2'd0;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic [ADDR_W-1:0] wb_addr;
  logic [WAY_W-1:0]  wb_way;
  logic              snoop_valid = 1'b0;
  logic [ADDR_W-1:0] snoop_addr = '0;
  logic              snoop_hit;
  logic              flush_req = 1'b0;
  logic              flush_done;
  logic [15:0]       wb_count;
  logic [15:0]       drop_count;
  logic              dup_err;

  llc_evict_buffer #(.N_WAY(N_WAY), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_addr(evict_addr),
    .evict_way(evict_way), .evict_mesi(evict_mesi),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_way(wb_way),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_hit(snoop_hit),
    .flush_req(flush_req), .flush_done(flush_done),
    .wb_count(wb_count), .drop_count(drop_count), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffer contents, expected writebacks, stats, flush phase (0 idle, 1 drain, 2 done)
  ent_t model_q[$];
  ent_t sb_q[$];
  int   exp_wbc   = 0;
  int   exp_drc   = 0;
  logic exp_snoop = 1'b0;
  logic exp_dup   = 1'b0;
  logic exp_done  = 1'b0;
  int   phase     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return (model_q.size() < DEPTH) && (phase == 0);
  endfunction

  // Predict the effect of the coming rising edge from the stable inputs.
  initial begin
    logic acc, is_m, hit, dupf, pop;
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        model_q.delete();
        sb_q.delete();
        exp_wbc = 0; exp_drc = 0; phase = 0;
        exp_snoop = 1'b0; exp_dup = 1'b0; exp_done = 1'b0;
      end else begin
        acc  = evict_valid && model_ready();
        is_m = (evict_mesi == 2'd3);
        hit  = 1'b0;
        dupf = 1'b0;
        foreach (model_q[i]) begin
          if (model_q[i].addr == snoop_addr) hit = 1'b1;
          if (model_q[i].addr == evict_addr) dupf = 1'b1;
        end
        exp_snoop = snoop_valid && (hit || (acc && is_m && (evict_addr == snoop_addr)));
        if (acc && is_m && dupf) exp_dup = 1'b1;
        if (acc && is_m && exp_wbc < 65535) exp_wbc++;
        if (acc && !is_m && exp_drc < 65535) exp_drc++;
        pop = (model_q.size() > 0) && wb_ready;
        case (phase)
          0: if (flush_req) phase = 1;
          1: if (model_q.size() == 0) phase = 2;
          default: phase = 0;
        endcase
        exp_done = (phase == 2);
        if (pop) void'(model_q.pop_front());
        if (acc && is_m) begin
          e.addr = evict_addr;
          e.way  = evict_way;
          model_q.push_back(e);
          sb_q.push_back(e);
        end
      end
    end
  end

  // Monitor: compare outputs mid-cycle and consume one scoreboard entry per handshake.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("evict_ready", {31'd0, evict_ready}, {31'd0, model_ready()});
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, model_q.size() != 0});
        chk("snoop_hit", {31'd0, snoop_hit}, {31'd0, exp_snoop});
        chk("flush_done", {31'd0, flush_done}, {31'd0, exp_done});
        chk("dup_err", {31'd0, dup_err}, {31'd0, exp_dup});
        chk("wb_count", {16'd0, wb_count}, exp_wbc);
        chk("drop_count", {16'd0, drop_count}, exp_drc);
        if (wb_valid && wb_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_pop: got writeback %h with nothing expected at %0t", wb_addr, $time);
          end else begin
            e = sb_q.pop_front();
            chk("wb_addr", wb_addr, e.addr);
            chk("wb_way", {28'd0, wb_way}, {28'd0, e.way});
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [3:0] w, input logic [1:0] m);
    evict_valid = 1'b1; evict_addr = a; evict_way = w; evict_mesi = m;
    tick(1);
    evict_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_evict_ready"}, {31'd0, evict_ready}, 32'd1);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wb_addr"}, wb_addr, 32'd0);
    chk({tag, "_wb_way"}, {28'd0, wb_way}, 32'd0);
    chk({tag, "_snoop_hit"}, {31'd0, snoop_hit}, 32'd0);
    chk({tag, "_flush_done"}, {31'd0, flush_done}, 32'd0);
    chk({tag, "_wb_count"}, {16'd0, wb_count}, 32'd0);
    chk({tag, "_drop_count"}, {16'd0, drop_count}, 32'd0);
    chk({tag, "_dup_err"}, {31'd0, dup_err}, 32'd0);
  endtask

  initial begin
    logic seen;
    tick(2);
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick(1);

    // Four modified victims fill the buffer, then drain in order.
    for (int i = 0; i < 4; i++) offer(32'h100 + i, 4'(i), 2'd3);
    chk("full_ready", {31'd0, evict_ready}, 32'd0);
    chk("fill_wb_count", {16'd0, wb_count}, 32'd4);
    wb_ready = 1'b1;
    tick(1);
    chk("ready_after_pop", {31'd0, evict_ready}, 32'd1);
    tick(3);
    wb_ready = 1'b0;
    tick(1);

    // Clean victims are acknowledged and dropped.
    do_reset();
    offer(32'h180, 4'd1, 2'd1);
    offer(32'h181, 4'd2, 2'd2);
    offer(32'h182, 4'd3, 2'd0);
    chk("clean_drop_count", {16'd0, drop_count}, 32'd3);
    chk("clean_wb_count", {16'd0, wb_count}, 32'd0);
    chk("clean_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Snoop against buffered, in-flight push and popping entries.
    offer(32'h200, 4'd5, 2'd3);
    snoop_valid = 1'b1; snoop_addr = 32'h200;
    tick(1);
    chk("snoop_buffered", {31'd0, snoop_hit}, 32'd1);
    snoop_addr = 32'h204;
    tick(1);
    chk("snoop_miss", {31'd0, snoop_hit}, 32'd0);
    snoop_addr = 32'h300;
    offer(32'h300, 4'd6, 2'd3);
    chk("snoop_push", {31'd0, snoop_hit}, 32'd1);
    snoop_addr = 32'h200; wb_ready = 1'b1;
    tick(1);
    chk("snoop_pop", {31'd0, snoop_hit}, 32'd1);
    snoop_valid = 1'b0; wb_ready = 1'b0;
    tick(1);
    chk("snoop_idle", {31'd0, snoop_hit}, 32'd0);

    // Steady push+pop at occupancy 2 across several pointer wraps.
    do_reset();
    offer(32'h3F0, 4'd1, 2'd3);
    offer(32'h3F1, 4'd2, 2'd3);
    wb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      evict_valid = 1'b1; evict_addr = 32'h400 + i; evict_way = 4'(i); evict_mesi = 2'd3;
      tick(1);
      chk("pp_ready", {31'd0, evict_ready}, 32'd1);
    end
    evict_valid = 1'b0;
    tick(3);
    chk("pp_drained", {31'd0, wb_valid}, 32'd0);
    wb_ready = 1'b0;

    // Flush with three entries buffered.
    do_reset();
    for (int i = 0; i < 3; i++) offer(32'h4A0 + i, 4'(i), 2'd3);
    pulse_flush();
    chk("flush_ready_lo", {31'd0, evict_ready}, 32'd0);
    tick(3);
    chk("flush_hold", {31'd0, evict_ready}, 32'd0);
    wb_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = flush_done;
    end
    chk("flush_done_seen", {31'd0, seen}, 32'd1);
    tick(1);
    chk("flush_ready_back", {31'd0, evict_ready}, 32'd1);
    wb_ready = 1'b0;
    pulse_flush();
    tick(3);

    // Asynchronous reset lands mid-drain.
    offer(32'h4B0, 4'd1, 2'd3);
    offer(32'h4B0, 4'd2, 2'd3);
    offer(32'h4B2, 4'd3, 2'd1);
    pulse_flush();
    tick(1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async");
    tick(2);
    rst = 1'b0;
    tick(1);

    // Duplicate modified victim sets a sticky error.
    offer(32'h500, 4'd1, 2'd3);
    offer(32'h500, 4'd2, 2'd3);
    chk("dup_set", {31'd0, dup_err}, 32'd1);
    wb_ready = 1'b1;
    tick(4);
    wb_ready = 1'b0;
    chk("dup_sticky", {31'd0, dup_err}, 32'd1);

    // Randomized traffic over a small address pool.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      evict_valid = 1'($urandom_range(0, 1));
      evict_addr  = 32'h600 + $urandom_range(0, 5);
      evict_way   = 4'($urandom_range(0, 15));
      evict_mesi  = 2'($urandom_range(0, 3));
      wb_ready    = ($urandom_range(0, 2) != 0);
      snoop_valid = 1'($urandom_range(0, 1));
      snoop_addr  = 32'h600 + $urandom_range(0, 6);
      flush_req   = ($urandom_range(0, 39) == 0);
      tick(1);
    end
    evict_valid = 1'b0; snoop_valid = 1'b0; flush_req = 1'b0; wb_ready = 1'b1;
    tick(20);
    wb_ready = 1'b0;

    // Drop counter saturation.
    do_reset();
    evict_valid = 1'b1; evict_addr = 32'h700; evict_way = 4'd0; evict_mesi = 2'd1;
    tick(65536);
    evict_valid = 1'b0;
    tick(1);
    chk("drop_sat", {16'd0, drop_count}, 32'h0000FFFF);
    offer(32'h701, 4'd1, 2'd2);
    chk("drop_sat_hold", {16'd0, drop_count}, 32'h0000FFFF);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
